// File: rtl/sys_cmd_dispatcher_pkg.sv
// Shared command codes and dispatcher FSM encoding for the UART command path.
package sys_cmd_dispatcher_pkg;

  typedef enum logic [2:0] {
    CMD_NONE    = 3'b000,
    CMD_RF_WR   = 3'b001,
    CMD_RF_RD   = 3'b010,
    CMD_ALU_OP  = 3'b011,
    CMD_ALU_FUN = 3'b100
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_WAIT  = 2'd1,
    ST_ALU_WAIT = 2'd2,
    ST_ALU_HI   = 2'd3
  } state_e;

  localparam int BYTE_W = 8;

endpackage

// File: rtl/sys_cmd_dispatcher_fifo.sv
// Synchronous response byte FIFO; DEPTH must be a power of two so pointers wrap naturally.
module resp_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             RXCont_CLK,
  input  logic             RXCont_RST,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign pop_data = mem[rd_ptr];

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge RXCont_CLK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge RXCont_CLK or negedge RXCont_RST) begin
    if (!RXCont_RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sys_cmd_dispatcher.sv
// Dispatches decoded UART commands to the register file / ALU and streams
// their results back to the UART transmitter through a small response FIFO.
module sys_cmd_dispatcher
  import sys_cmd_dispatcher_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int FUN_W      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              RXCont_CLK,
  input  logic              RXCont_RST,
  input  logic [7:0]        Disp_In_Data,
  input  logic [7:0]        Disp_In_Addr,
  input  logic [2:0]        Disp_In_Command,
  output logic              RF_WrEn,
  output logic              RF_RdEn,
  output logic [ADDR_W-1:0] RF_Address,
  output logic [7:0]        RF_WrData,
  input  logic [7:0]        RF_RdData,
  input  logic              RF_RdData_Valid,
  output logic              ALU_En,
  output logic [FUN_W-1:0]  ALU_Fun,
  input  logic [15:0]       ALU_Out,
  input  logic              ALU_Out_Valid,
  output logic [7:0]        TX_P_Data,
  output logic              TX_Data_Valid,
  input  logic              TX_Busy,
  output logic              Disp_Busy,
  output logic              Disp_Drop
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] EX_MAX_CNT = CNT_W'(FIFO_DEPTH - 2);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [BYTE_W-1:0]   alu_hi_q;
  logic                wr_go, op_go, rd_go, ex_go, drop_d;
  logic                cmd_vld;
  logic                push, pop;
  logic [BYTE_W-1:0]   push_data, fifo_head;
  logic                fifo_empty, fifo_full;
  logic [CNT_W-1:0]    fifo_count;
  logic                unused_addr_hi;

  assign unused_addr_hi = ^Disp_In_Addr[7:ADDR_W];
  assign cmd_vld        = (Disp_In_Command != CMD_NONE);
  assign Disp_Busy      = (state_q != ST_IDLE);

  // The one-cycle gap after every strobe lets the transmitter raise busy in time.
  assign pop = !fifo_empty && !TX_Busy && !TX_Data_Valid;

  resp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .RXCont_CLK (RXCont_CLK),
    .RXCont_RST (RXCont_RST),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .pop_data   (fifo_head),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .count      (fifo_count)
  );

  always_ff @(posedge RXCont_CLK or negedge RXCont_RST) begin
    if (!RXCont_RST) begin
      state_q  <= ST_IDLE;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    wr_go     = 1'b0;
    op_go     = 1'b0;
    rd_go     = 1'b0;
    ex_go     = 1'b0;
    drop_d    = 1'b0;
    push      = 1'b0;
    push_data = RF_RdData;
    unique case (state_q)
      ST_IDLE: begin
        case (Disp_In_Command)
          CMD_NONE:   ;
          CMD_RF_WR:  wr_go = 1'b1;
          CMD_ALU_OP: op_go = 1'b1;
          CMD_RF_RD: begin
            if (fifo_full) drop_d = 1'b1;
            else begin
              rd_go    = 1'b1;
              state_d  = ST_RD_WAIT;
              to_cnt_d = '0;
            end
          end
          CMD_ALU_FUN: begin
            // Both result bytes must fit before the ALU is started.
            if (fifo_count > EX_MAX_CNT) drop_d = 1'b1;
            else begin
              ex_go    = 1'b1;
              state_d  = ST_ALU_WAIT;
              to_cnt_d = '0;
            end
          end
          default: drop_d = 1'b1;
        endcase
      end
      ST_RD_WAIT: begin
        drop_d = cmd_vld;
        if (RF_RdData_Valid) begin
          push    = 1'b1;
          state_d = ST_IDLE;
        end else if (to_cnt_q == TO_LAST) begin
          drop_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_ALU_WAIT: begin
        drop_d = cmd_vld;
        if (ALU_Out_Valid) begin
          push      = 1'b1;
          push_data = ALU_Out[7:0];
          state_d   = ST_ALU_HI;
        end else if (to_cnt_q == TO_LAST) begin
          drop_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_ALU_HI: begin
        drop_d    = cmd_vld;
        push      = 1'b1;
        push_data = alu_hi_q;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge RXCont_CLK) begin
    if (state_q == ST_ALU_WAIT && ALU_Out_Valid) alu_hi_q <= ALU_Out[15:8];
  end

  // Registered outputs: strobes appear the cycle after the command is sampled.
  always_ff @(posedge RXCont_CLK or negedge RXCont_RST) begin
    if (!RXCont_RST) begin
      RF_WrEn       <= 1'b0;
      RF_RdEn       <= 1'b0;
      RF_Address    <= '0;
      RF_WrData     <= '0;
      ALU_En        <= 1'b0;
      ALU_Fun       <= '0;
      TX_P_Data     <= '0;
      TX_Data_Valid <= 1'b0;
      Disp_Drop     <= 1'b0;
    end else begin
      RF_WrEn       <= wr_go | op_go;
      RF_RdEn       <= rd_go;
      ALU_En        <= ex_go;
      TX_Data_Valid <= pop;
      Disp_Drop     <= drop_d;
      if (wr_go || rd_go) RF_Address <= Disp_In_Addr[ADDR_W-1:0];
      else if (op_go)     RF_Address <= ADDR_W'(Disp_In_Addr[0]);
      if (wr_go || op_go) RF_WrData <= Disp_In_Data;
      if (ex_go)          ALU_Fun   <= Disp_In_Data[FUN_W-1:0];
      if (pop)            TX_P_Data <= fifo_head;
    end
  end

endmodule

// File: tb/tb_sys_cmd_dispatcher.sv
// Self-checking bench for sys_cmd_dispatcher: cycle model plus directed literal checks.
module tb_sys_cmd_dispatcher;

  localparam int TIMEOUT    = 16;
  localparam int FIFO_DEPTH = 4;

  logic        RXCont_CLK = 1'b0;
  logic        RXCont_RST = 1'b0;
  logic [7:0]  Disp_In_Data = '0;
  logic [7:0]  Disp_In_Addr = '0;
  logic [2:0]  Disp_In_Command = '0;
  logic        RF_WrEn, RF_RdEn, ALU_En, TX_Data_Valid, Disp_Busy, Disp_Drop;
  logic [3:0]  RF_Address, ALU_Fun;
  logic [7:0]  RF_WrData, TX_P_Data;
  logic [7:0]  RF_RdData = '0;
  logic        RF_RdData_Valid = 1'b0;
  logic [15:0] ALU_Out = '0;
  logic        ALU_Out_Valid = 1'b0;
  logic        TX_Busy = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  sys_cmd_dispatcher #(
    .ADDR_W (4), .FUN_W (4), .FIFO_DEPTH (FIFO_DEPTH), .TIMEOUT (TIMEOUT)
  ) u_dut (
    .RXCont_CLK (RXCont_CLK), .RXCont_RST (RXCont_RST),
    .Disp_In_Data (Disp_In_Data), .Disp_In_Addr (Disp_In_Addr),
    .Disp_In_Command (Disp_In_Command),
    .RF_WrEn (RF_WrEn), .RF_RdEn (RF_RdEn), .RF_Address (RF_Address),
    .RF_WrData (RF_WrData), .RF_RdData (RF_RdData), .RF_RdData_Valid (RF_RdData_Valid),
    .ALU_En (ALU_En), .ALU_Fun (ALU_Fun), .ALU_Out (ALU_Out), .ALU_Out_Valid (ALU_Out_Valid),
    .TX_P_Data (TX_P_Data), .TX_Data_Valid (TX_Data_Valid), .TX_Busy (TX_Busy),
    .Disp_Busy (Disp_Busy), .Disp_Drop (Disp_Drop)
  );

  always #5 RXCont_CLK = ~RXCont_CLK;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 waiting for read data, 2 waiting for ALU, 3 ALU high byte pending
  int          m_mode, m_wait, m_nmode, m_cnt;
  logic [7:0]  m_q[$];
  logic [7:0]  m_hi;
  logic        m_pop;
  logic        e_wr, e_rd, e_en, e_drop, e_txv;
  logic [3:0]  e_addr, e_fun;
  logic [7:0]  e_wdata, e_txd;

  always @(posedge RXCont_CLK or negedge RXCont_RST) begin
    if (!RXCont_RST) begin
      m_mode = 0; m_wait = 0; m_q.delete(); m_hi = '0;
      e_wr = 0; e_rd = 0; e_en = 0; e_drop = 0; e_txv = 0;
      e_addr = '0; e_fun = '0; e_wdata = '0; e_txd = '0;
    end else begin
      m_cnt   = m_q.size();
      m_pop   = (m_cnt > 0) && !TX_Busy && !e_txv;
      m_nmode = m_mode;
      e_wr = 0; e_rd = 0; e_en = 0; e_drop = 0;
      if (Disp_In_Command != 3'd0) begin
        if (m_mode != 0) e_drop = 1;
        else case (Disp_In_Command)
          3'd1: begin e_wr = 1; e_addr = Disp_In_Addr[3:0]; e_wdata = Disp_In_Data; end
          3'd3: begin e_wr = 1; e_addr = {3'b000, Disp_In_Addr[0]}; e_wdata = Disp_In_Data; end
          3'd2: if (FIFO_DEPTH - m_cnt >= 1) begin
                  e_rd = 1; e_addr = Disp_In_Addr[3:0]; m_nmode = 1; m_wait = 0;
                end else e_drop = 1;
          3'd4: if (FIFO_DEPTH - m_cnt >= 2) begin
                  e_en = 1; e_fun = Disp_In_Data[3:0]; m_nmode = 2; m_wait = 0;
                end else e_drop = 1;
          default: e_drop = 1;
        endcase
      end
      if (m_pop) e_txd = m_q.pop_front();
      e_txv = m_pop;
      if (m_mode == 1 || m_mode == 2) begin
        if (m_mode == 1 && RF_RdData_Valid) begin
          m_q.push_back(RF_RdData); m_nmode = 0;
        end else if (m_mode == 2 && ALU_Out_Valid) begin
          m_q.push_back(ALU_Out[7:0]); m_hi = ALU_Out[15:8]; m_nmode = 3;
        end else if (m_wait + 1 == TIMEOUT) begin
          e_drop = 1; m_nmode = 0;
        end else m_wait++;
      end else if (m_mode == 3) begin
        m_q.push_back(m_hi); m_nmode = 0;
      end
      m_mode = m_nmode;
    end
  end

  always @(negedge RXCont_CLK) begin
    check("RF_WrEn", RF_WrEn, e_wr);
    check("RF_RdEn", RF_RdEn, e_rd);
    check("RF_Address", RF_Address, e_addr);
    check("RF_WrData", RF_WrData, e_wdata);
    check("ALU_En", ALU_En, e_en);
    check("ALU_Fun", ALU_Fun, e_fun);
    check("Disp_Drop", Disp_Drop, e_drop);
    check("Disp_Busy", Disp_Busy, m_mode != 0);
    check("TX_Data_Valid", TX_Data_Valid, e_txv);
    check("TX_P_Data", TX_P_Data, e_txd);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge RXCont_CLK);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] c, input logic [7:0] a, input logic [7:0] d);
    Disp_In_Command = c; Disp_In_Addr = a; Disp_In_Data = d;
    tick();
    Disp_In_Command = '0;
  endtask

  task automatic read_with_data(input logic [7:0] a, input logic [7:0] d);
    send_cmd(3'd2, a, 8'h00);
    RF_RdData = d; RF_RdData_Valid = 1'b1;
    tick();
    RF_RdData_Valid = 1'b0;
  endtask

  logic [7:0] got_b[$];
  int         got_c[$];

  initial begin
    repeat (3) tick();
    check("rst_TX_Data_Valid", TX_Data_Valid, 0);
    check("rst_RF_WrEn", RF_WrEn, 0);
    check("rst_ALU_Fun", ALU_Fun, 0);
    check("rst_Disp_Busy", Disp_Busy, 0);
    RXCont_RST = 1'b1;
    repeat (2) tick();

    // RF write
    send_cmd(3'd1, 8'h05, 8'h3C);
    check("wr_en", RF_WrEn, 1);
    check("wr_addr", RF_Address, 4'h5);
    check("wr_data", RF_WrData, 8'h3C);
    tick();
    check("wr_en_one_cycle", RF_WrEn, 0);

    // RF read, data three cycles after the command
    send_cmd(3'd2, 8'h02, 8'h00);
    check("rd_en", RF_RdEn, 1);
    check("rd_addr", RF_Address, 4'h2);
    tick(); tick();
    RF_RdData = 8'hA5; RF_RdData_Valid = 1'b1;
    tick();
    RF_RdData_Valid = 1'b0;
    check("rd_back_idle", Disp_Busy, 0);
    tick();
    check("rd_tx_valid", TX_Data_Valid, 1);
    check("rd_tx_byte", TX_P_Data, 8'hA5);
    tick();

    // ALU operands then execute
    send_cmd(3'd3, 8'h00, 8'h10);
    check("op_a_addr", RF_Address, 4'h0);
    check("op_a_data", RF_WrData, 8'h10);
    send_cmd(3'd3, 8'hF1, 8'h20);
    check("op_b_addr", RF_Address, 4'h1);
    check("op_b_data", RF_WrData, 8'h20);
    send_cmd(3'd4, 8'h00, 8'h01);
    check("alu_en", ALU_En, 1);
    check("alu_fun", ALU_Fun, 4'h1);
    tick();
    ALU_Out = 16'h1234; ALU_Out_Valid = 1'b1;
    tick();
    ALU_Out_Valid = 1'b0;
    check("alu_hi_busy", Disp_Busy, 1);
    tick();
    check("alu_lo_valid", TX_Data_Valid, 1);
    check("alu_lo_byte", TX_P_Data, 8'h34);
    tick();
    check("alu_gap", TX_Data_Valid, 0);
    tick();
    check("alu_hi_valid", TX_Data_Valid, 1);
    check("alu_hi_byte", TX_P_Data, 8'h12);
    tick();

    // Backpressure: queue results while the transmitter is busy
    TX_Busy = 1'b1;
    read_with_data(8'h01, 8'h11);
    read_with_data(8'h02, 8'h22);
    read_with_data(8'h03, 8'h33);
    tick();
    check("bp_count3", u_dut.u_fifo.count, 3);
    check("bp_no_tx", TX_Data_Valid, 0);
    send_cmd(3'd4, 8'h00, 8'h07);
    check("ex_no_room_drop", Disp_Drop, 1);
    check("ex_no_room_en", ALU_En, 0);
    read_with_data(8'h04, 8'h44);
    send_cmd(3'd2, 8'h05, 8'h00);
    check("rd_full_drop", Disp_Drop, 1);
    check("rd_full_en", RF_RdEn, 0);
    tick();
    TX_Busy = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (TX_Data_Valid) begin
        got_b.push_back(TX_P_Data);
        got_c.push_back(c);
      end
    end
    check("bp_strobes", got_b.size(), 4);
    if (got_b.size() == 4) begin
      check("bp_b0", got_b[0], 8'h11);
      check("bp_b1", got_b[1], 8'h22);
      check("bp_b2", got_b[2], 8'h33);
      check("bp_b3", got_b[3], 8'h44);
      for (int i = 1; i < 4; i++) check("bp_spacing", (got_c[i] - got_c[i-1]) >= 2, 1);
    end

    // Read timeout
    send_cmd(3'd2, 8'h03, 8'h00);
    repeat (TIMEOUT - 1) tick();
    check("to_not_yet", Disp_Drop, 0);
    check("to_still_busy", Disp_Busy, 1);
    tick();
    check("to_drop", Disp_Drop, 1);
    check("to_idle", Disp_Busy, 0);
    tick();

    // Illegal opcode
    send_cmd(3'd7, 8'h01, 8'h01);
    check("bad_cmd_drop", Disp_Drop, 1);
    check("bad_cmd_wr", RF_WrEn, 0);
    tick();

    // Reset while waiting on the ALU with two bytes queued
    TX_Busy = 1'b1;
    read_with_data(8'h06, 8'h66);
    read_with_data(8'h07, 8'h77);
    send_cmd(3'd4, 8'h00, 8'h02);
    send_cmd(3'd1, 8'h09, 8'h55);
    check("busy_wr_drop", Disp_Drop, 1);
    check("busy_wr_en", RF_WrEn, 0);
    check("pre_rst_count", u_dut.u_fifo.count, 2);
    RXCont_RST = 1'b0;
    #1;
    check("arst_busy", Disp_Busy, 0);
    check("arst_fun", ALU_Fun, 0);
    check("arst_drop", Disp_Drop, 0);
    check("arst_count", u_dut.u_fifo.count, 0);
    tick();
    RXCont_RST = 1'b1;
    TX_Busy = 1'b0;
    ALU_Out = 16'hBEEF; ALU_Out_Valid = 1'b1;
    RF_RdData = 8'h99; RF_RdData_Valid = 1'b1;
    tick();
    ALU_Out_Valid = 1'b0; RF_RdData_Valid = 1'b0;
    repeat (4) tick();
    check("stray_count", u_dut.u_fifo.count, 0);
    check("stray_tx", TX_Data_Valid, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sys_cmd_dispatcher.md
# sys_cmd_dispatcher

Command dispatcher directly downstream of the UART RX frame controller, on the same system clock. It consumes the decoded single-cycle command, address and data strobes. It drives the register file and ALU ports, waits for their results, and queues response bytes in a small FIFO. It then hands those bytes one at a time to the UART TX path under a busy handshake.

## Interface
- ADDR_W, 4, register-file address width; `Disp_In_Addr[ADDR_W-1:0]` used
- FUN_W, 4, ALU function width; `Disp_In_Data[FUN_W-1:0]` used
- FIFO_DEPTH, 4, response FIFO depth in bytes (power of 2)
- TIMEOUT, 16, max wait cycles for an RF/ALU result
- RXCont_CLK  in  1  system clock; all logic on rising edge
- RXCont_RST  in  1  asynchronous, active-low reset
- Disp_In_Data  in  8  command payload (write data / operand / function)
- Disp_In_Addr  in  8  command address
- Disp_In_Command  in  3  000 none, 001 RF write, 010 RF read, 011 ALU operand write, 100 ALU execute; valid exactly one cycle
- RF_WrEn / RF_RdEn  out  1  one-cycle strobes
- RF_Address  out  ADDR_W  register address
- RF_WrData  out  8  write data
- RF_RdData  in  8  read data, qualified by RF_RdData_Valid
- RF_RdData_Valid  in  1  read-data strobe
- ALU_En  out  1  one-cycle execute strobe
- ALU_Fun  out  FUN_W  function code, held until the next execute
- ALU_Out  in  16  result, qualified by ALU_Out_Valid
- ALU_Out_Valid  in  1  result strobe
- TX_P_Data  out  8  byte to transmitter
- TX_Data_Valid  out  1  one-cycle strobe
- TX_Busy  in  1  transmitter busy
- Disp_Busy  out  1  high whenever the FSM is not in IDLE (combinational)
- Disp_Drop  out  1  one-cycle pulse when a command is rejected or a wait times out

## Operation
- Reset: FSM IDLE, FIFO empty, timeout counter 0, every output 0 (including ALU_Fun).
- FSM states: IDLE, RD_WAIT, ALU_WAIT, ALU_HI. Commands are accepted only in IDLE.
- A non-zero command is dropped (Disp_Drop) if it arrives outside IDLE, if its code is 101/110/111, if it is a read with FIFO free < 1, or if it is an execute with FIFO free < 2.
- 001: RF_WrEn=1, RF_Address=Addr[ADDR_W-1:0], RF_WrData=Data; FSM stays in IDLE.
- 011: same as 001, except RF_Address={0…,Addr[0]} (operand A = reg 0, operand B = reg 1).
- 010: RF_RdEn=1 with address; go to RD_WAIT. On RF_RdData_Valid, push RF_RdData and go to IDLE.
- 100: ALU_En=1, ALU_Fun=Data[FUN_W-1:0]; go to ALU_WAIT.
  - On ALU_Out_Valid, capture ALU_Out, push the low byte, go to ALU_HI.
  - In ALU_HI, push the high byte unconditionally and go to IDLE.
- Timeout: the counter clears on entry to RD_WAIT/ALU_WAIT and increments each wait cycle. When it reaches TIMEOUT-1 with no strobe, pulse Disp_Drop, go to IDLE, push nothing.
- Result strobes seen outside the matching wait state are ignored.
- FIFO: pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
  - Simultaneous push and pop leaves the count unchanged.
  - Overflow cannot occur because free space is checked at command acceptance.
- TX: pop when FIFO is non-empty, TX_Busy=0, and TX_Data_Valid was 0 in the previous cycle. This guarantees at least one idle cycle between strobes so the TX can raise busy.

## Timing
- Command at cycle N → RF_WrEn / RF_RdEn / ALU_En high in cycle N+1 only (registered).
- RD_WAIT / ALU_WAIT are entered at N+1 and sample strobes from N+1 onward.
- Push at edge ending cycle M → FIFO non-empty at M+1 → TX_Data_Valid at M+2 at the earliest.
- ALU result strobe at M → low byte pushed at end of M, high byte at end of M+1. TX sees low byte first, then high byte no sooner than 2 cycles later.
- Disp_Drop is registered: it is high in N+1 for a rejected command, and in the cycle after the timeout is detected.
- Reset mid-operation: immediate return to reset state; FIFO contents and any pending result are lost.

## Structure
- Shared package: command codes (CMD_NONE, CMD_RF_WR=3'b001, CMD_RF_RD=3'b010, CMD_ALU_OP=3'b011, CMD_ALU_FUN=3'b100) and FSM state encoding.
- Sub-module: `resp_fifo`, a synchronous byte FIFO with push/pop, empty/full, and a count output used for the free-space checks.

## Test plan
- Command 001, Addr=0x05, Data=0x3C → RF_WrEn one cycle at N+1 with RF_Address=5, RF_WrData=0x3C; no TX activity.
- Command 010, Addr=0x02; RF_RdData=0xA5 with valid 3 cycles later → TX_P_Data=0xA5 with TX_Data_Valid 2 cycles after the valid strobe; FSM back in IDLE.
- 011 with Addr=0, Data=0x10; 011 with Addr=1, Data=0x20; 100 with Data=0x1; ALU_Out=0x1234 valid → RF writes to regs 0/1, ALU_Fun=1, TX bytes 0x34 then 0x12.
- Hold TX_Busy=1 while three read results queue → count=3, no TX strobe; release busy → three strobes in order, each separated by at least 1 idle cycle.
- Read with no RF_RdData_Valid → Disp_Drop after TIMEOUT cycles, FSM in IDLE. A command 111, and a write arriving during ALU_WAIT → Disp_Drop each, with no RF strobe.
- Assert reset during ALU_WAIT with 2 bytes queued → all outputs 0, FIFO empty; a later ALU_Out_Valid is ignored.
